led_display_ctrl: RTL and testbench



---
 rtl/led_display_ctrl_pkg.sv | 37 +++
 rtl/led_display_ctrl_if.sv | 12 +
 rtl/led_display_ctrl_scan_timer.sv | 30 +++
 rtl/led_display_ctrl.sv | 83 ++++++++
 tb/tb_led_display_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_display_ctrl_pkg.sv
// Shared constants, register field positions and the hex-to-7-segment decoder
// for the LED display peripheral and other scanned displays.
package led_pkg;

   localparam logic [31:0] LED_ADDR_DEF = 32'h4000_0010;
   localparam int          DIGIT_LSB    = 0;
   localparam int          DP_LSB       = 16;
   localparam int          EN_BIT       = 20;
   localparam logic [31:0] REG_MASK     = 32'h001F_FFFF;

   typedef logic [6:0] seg7_t;

   // Active-high {g,f,e,d,c,b,a}; callers invert for common-anode drive.
   function automatic seg7_t hex2seg(input logic [3:0] hex);
      seg7_t pat;
      case (hex)
         4'h0:    pat = 7'h3F;
         4'h1:    pat = 7'h06;
         4'h2:    pat = 7'h5B;
         4'h3:    pat = 7'h4F;
         4'h4:    pat = 7'h66;
         4'h5:    pat = 7'h6D;
         4'h6:    pat = 7'h7D;
         4'h7:    pat = 7'h07;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h6F;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h7C;
         4'hC:    pat = 7'h39;
         4'hD:    pat = 7'h5E;
         4'hE:    pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/led_display_ctrl_if.sv
// Decoder-side bus for the LED region: byte address, store/load data and the
// single-cycle read/write strobes.
interface led_display_ctrl_if;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        mem_wr;
   logic        mem_rd;

   modport master (output addr, data_in, mem_wr, mem_rd, input data_out);
   modport slave  (input addr, data_in, mem_wr, mem_rd, output data_out);
endinterface

// File: rtl/led_display_ctrl_scan_timer.sv
// Free-running slot timer: divides clk by SCAN_DIV and steps a 2-bit digit index.
module led_scan_timer #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       tick,
   output logic [1:0] idx
);

   localparam int                CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt <= '0;
         idx     <= 2'd0;
      end else if (tick) begin
         div_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_display_ctrl.sv
// Memory-mapped 4-digit multiplexed 7-segment controller (common anode).
// Build option: define LED_ZERO_BLANK_EN for leading-zero blanking.
module led_display_ctrl
   import led_pkg::*;
#(
   parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
   parameter int          SCAN_DIV = 50000,
   parameter int          DIGITS   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   led_display_ctrl_if.slave bus,
   output logic [DIGITS-1:0] an,
   output logic [7:0]        seg
);

   logic [31:0]       disp_reg;
   logic              addr_hit;
   logic              scan_tick;
   logic [1:0]        scan_idx;
   logic [3:0]        digit;
   logic [3:0]        dp_bits;
   logic [15:0]       upper_digits;
   logic              blank;
   logic [DIGITS-1:0] an_p0;
   logic [7:0]        seg_p0;
   logic [DIGITS-1:0] an_p1;
   logic [7:0]        seg_p1;

   assign addr_hit     = (bus.addr == LED_ADDR);
   assign bus.data_out = (bus.mem_rd && addr_hit) ? disp_reg : 32'h0;

   always_ff @(posedge clk) begin
      if (!reset_n)
         disp_reg <= 32'h0;
      else if (bus.mem_wr && addr_hit)
         disp_reg <= bus.data_in & REG_MASK;
   end

   led_scan_timer #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (scan_tick),
      .idx     (scan_idx)
   );

   // ---- p0: select the active digit and decode it ----
   assign digit        = disp_reg[DIGIT_LSB + {scan_idx, 2'b00} +: 4];
   assign dp_bits      = disp_reg[DP_LSB +: 4];
   assign upper_digits = disp_reg[15:0] >> {scan_idx, 2'b00};

`ifdef LED_ZERO_BLANK_EN
   assign blank = (scan_idx != 2'd0) && (upper_digits == 16'h0);
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_p0  = '1;
      seg_p0 = 8'hFF;
      if (disp_reg[EN_BIT] && !blank) begin
         an_p0  = ~(DIGITS'(1) << scan_idx);
         seg_p0 = {~dp_bits[scan_idx], ~hex2seg(digit)};
      end
   end

   // ---- p1: registered pin drive, so anode/segment switch together ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         an_p1  <= '1;
         seg_p1 <= 8'hFF;
      end else begin
         an_p1  <= an_p0;
         seg_p1 <= seg_p0;
      end
   end

   assign an  = an_p1;
   assign seg = seg_p1;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Randomised self-checking bench for led_display_ctrl against a slot-level model.
module tb_led_display_ctrl;
   localparam int          SD   = 4;
   localparam logic [31:0] A    = 32'h4000_0010;
   localparam logic [31:0] MASK = 32'h001F_FFFF;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] an;
   logic [7:0] seg;

   led_display_ctrl_if bus();

   led_display_ctrl #(.LED_ADDR(A), .SCAN_DIV(SD), .DIGITS(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .an(an), .seg(seg));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_reg = 32'h0;
   int          m_cnt = 0;
   int          m_slot = 0;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg;
   logic [6:0]  pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [11:0] model_disp(input logic [31:0] r, input int slot);
      logic [3:0] d;
      logic       all_zero;
      logic [3:0] a;
      if (!r[20]) return {4'hF, 8'hFF};
      all_zero = 1'b1;
      for (int k = slot; k < 4; k++)
         if (r[4*k +: 4] != 4'h0) all_zero = 1'b0;
`ifdef LED_ZERO_BLANK_EN
      if (slot > 0 && all_zero) return {4'hF, 8'hFF};
`endif
      d = r[4*slot +: 4];
      a = 4'hF;
      a[slot] = 1'b0;
      return {a, ~r[16+slot], ~pat[d]};
   endfunction

   // One clock: predict pin values from pre-edge state, then advance the model.
   task automatic tick();
      logic [11:0] e;
      m_slot = (m_cnt / SD) % 4;
      if (!reset_n) e = {4'hF, 8'hFF};
      else          e = model_disp(m_reg, m_slot);
      exp_an  = e[11:8];
      exp_seg = e[7:0];
      if (!reset_n) begin
         m_reg = 32'h0;
         m_cnt = 0;
      end else begin
         if (bus.mem_wr && bus.addr == A) m_reg = bus.data_in & MASK;
         m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [31:0] ad, input logic [31:0] d);
      bus.mem_wr  = wr;
      bus.mem_rd  = rd;
      bus.addr    = ad;
      bus.data_in = d;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 1, A, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want F", an); end
         checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want FF", seg); end
      end
      checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_read got %h want 0", bus.data_out); end
      reset_n = 1'b1;
      drive(0, 0, A, 32'h0);
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL disabled_out got %h/%h want F/FF", an, seg); end
      end
   endtask

   task automatic test_scan();
      drive(1, 0, A, 32'h0010_1234);
      tick();
      drive(0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 24; i++) begin
         tick();
         checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an slot %0d got %h want %h", m_slot, an, exp_an); end
         checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg slot %0d got %h want %h", m_slot, seg, exp_seg); end
         if (m_slot == 0) begin
            checks++; if (seg !== 8'h99) begin errors++; $display("FAIL scan_digit4 got %h want 99", seg); end
         end
      end
   endtask

   task automatic test_mask_addr();
      drive(1, 0, A, 32'hFFFF_FFFF);
      tick();
      drive(0, 1, A, 32'h0);
      #1;
      checks++; if (bus.data_out !== 32'h001F_FFFF) begin errors++; $display("FAIL mask_read got %h want 001FFFFF", bus.data_out); end
      tick();
      drive(1, 1, 32'h4000_0014, 32'h0000_0000);
      #1;
      checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL other_addr_read got %h want 0", bus.data_out); end
      tick();
      drive(0, 1, A, 32'h0);
      #1;
      checks++; if (bus.data_out !== m_reg) begin errors++; $display("FAIL other_addr_write got %h want %h", bus.data_out, m_reg); end
      tick();
      checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL mask_disp got %h/%h want %h/%h", an, seg, exp_an, exp_seg); end
   endtask

   task automatic test_rw_same();
      drive(1, 0, A, 32'h0010_1234);
      tick();
      drive(1, 1, A, 32'h0010_0005);
      #1;
      checks++; if (bus.data_out !== 32'h0010_1234) begin errors++; $display("FAIL rw_old got %h want 00101234", bus.data_out); end
      tick();
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL rw_seg_before got %h want %h", seg, exp_seg); end
      drive(0, 1, A, 32'h0);
      #1;
      checks++; if (bus.data_out !== 32'h0010_0005) begin errors++; $display("FAIL rw_new got %h want 00100005", bus.data_out); end
      tick();
      checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL rw_seg_after got %h/%h want %h/%h", an, seg, exp_an, exp_seg); end
   endtask

   task automatic test_reset_mid();
      int guard;
      drive(1, 0, A, 32'h0010_1234);
      tick();
      drive(0, 0, 32'h0, 32'h0);
      guard = 0;
      while (((m_cnt / SD) % 4) != 2 && guard < 64) begin
         tick();
         guard++;
      end
      checks++; if (guard >= 64) begin errors++; $display("FAIL mid_wait got %0d want <64", guard); end
      reset_n = 1'b0;
      tick();
      checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL mid_reset got %h/%h want F/FF", an, seg); end
      drive(0, 1, A, 32'h0);
      #1;
      checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL mid_reset_reg got %h want 0", bus.data_out); end
      reset_n = 1'b1;
      drive(1, 0, A, 32'h0010_1234);
      tick();
      checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL restart_first got %h/%h want %h/%h", an, seg, exp_an, exp_seg); end
      drive(0, 0, 32'h0, 32'h0);
      tick();
      checks++; if (an !== 4'hE || seg !== 8'h99) begin errors++; $display("FAIL restart_idx0 got %h/%h want E/99", an, seg); end
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL restart_scan got %h/%h want %h/%h", an, seg, exp_an, exp_seg); end
      end
   endtask

   task automatic test_random();
      logic        wr, rd;
      logic [31:0] ad, d, exp_rd;
      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 5) == 0);
         rd = $urandom_range(0, 1);
         ad = ($urandom_range(0, 3) == 0) ? $urandom : A;
         d  = $urandom;
         d[20] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
         reset_n = ($urandom_range(0, 79) != 0);
         drive(wr, rd, ad, d);
         #1;
         exp_rd = (rd && ad == A) ? m_reg : 32'h0;
         checks++; if (bus.data_out !== exp_rd) begin errors++; $display("FAIL rand_read got %h want %h", bus.data_out, exp_rd); end
         tick();
         checks++; if (an !== exp_an || seg !== exp_seg) begin errors++; $display("FAIL rand_disp got %h/%h want %h/%h", an, seg, exp_an, exp_seg); end
      end
      reset_n = 1'b1;
   endtask

`ifdef LED_ZERO_BLANK_EN
   task automatic test_blank();
      drive(1, 0, A, 32'h0011_0005);
      tick();
      drive(0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) begin
         tick();
         if (m_slot == 0) begin
            checks++; if (an !== 4'hE || seg !== 8'h12) begin errors++; $display("FAIL blank_slot0 got %h/%h want E/12", an, seg); end
         end else begin
            checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL blank_slot%0d got %h/%h want F/FF", m_slot, an, seg); end
         end
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout reached");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 32'h0, 32'h0);
      #1;
      test_reset();
      test_scan();
      test_mask_addr();
      test_rw_same();
      test_reset_mid();
`ifdef LED_ZERO_BLANK_EN
      test_blank();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
